// File: rtl/range_limited_pkg.sv
// Shared types and constants for the range-limited pipeline front end.
// A record is three fp32 coordinates tagged with a demux destination.
package range_limited_pkg;

    localparam int DATA_WIDTH       = 96;
    localparam int SEL_WIDTH        = 7;
    localparam int NUM_OUTPUT_PORTS = 128;
    localparam int NUM_ACTIVE_PORTS = 100;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } particle_t;

    typedef logic [SEL_WIDTH-1:0] dest_t;

    typedef struct packed {
        dest_t     dest;
        particle_t rec;
    } fifo_entry_t;

    // Ports at or above the populated range have nothing attached.
    function automatic logic dest_is_legal(input dest_t d);
        return d < dest_t'(NUM_ACTIVE_PORTS);
    endfunction

endpackage

// File: rtl/dispatch_fifo_mem.sv
// Storage for the dispatch FIFO: synchronous write, asynchronous read.
// No reset: stale contents are never visible because occupancy is tracked outside.
module dispatch_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 103
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/demux_dispatch_buffer.sv
// Buffers tagged particle records and feeds the backpressure-free demux tree
// one registered record per cycle, dropping and counting unpopulated destinations.
module demux_dispatch_buffer
    import range_limited_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [SEL_WIDTH-1:0]     in_dest,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_hold,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [SEL_WIDTH-1:0]     out_sel,
    output logic                     out_valid,
    output logic [FIFO_ADDR_WIDTH:0] out_count,
    output logic [15:0]              out_drop_cnt
);

    localparam logic [FIFO_ADDR_WIDTH:0] FULL_COUNT = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam int ENTRY_W = $bits(fifo_entry_t);

    logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0]      r_out_data;
    logic [SEL_WIDTH-1:0]       r_out_sel;
    logic                       r_out_valid;
    logic [15:0]                r_drop_cnt;

    fifo_entry_t w_wr_entry;
    fifo_entry_t w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_legal;

    // Full is judged from occupancy alone, so a same-cycle pop never frees a slot.
    assign in_ready = (r_count != FULL_COUNT);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_count != '0) && !in_hold;
    assign w_legal  = dest_is_legal(w_head.dest);

    assign w_wr_entry.dest = in_dest;
    assign w_wr_entry.rec  = in_data;

    dispatch_fifo_mem #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_ADDR_WIDTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Illegal heads are consumed silently; data/sel keep the last legal record.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_out_valid <= w_pop && w_legal;
            if (w_pop && w_legal) begin
                r_out_data <= w_head.rec;
                r_out_sel  <= w_head.dest;
            end
            if (w_pop && !w_legal && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign out_data     = r_out_data;
    assign out_sel      = r_out_sel;
    assign out_valid    = r_out_valid;
    assign out_count    = r_count;
    assign out_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_demux_dispatch_buffer.sv
// Bench for demux_dispatch_buffer: constant vector table, directed corner
// sequences and random traffic, all checked against a queue-based model.
module tb_demux_dispatch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] in_data;
    logic [6:0]  in_dest;
    logic        in_valid;
    logic        in_ready;
    logic        in_hold;
    logic [95:0] out_data;
    logic [6:0]  out_sel;
    logic        out_valid;
    logic [4:0]  out_count;
    logic [15:0] out_drop_cnt;

    int checks = 0;
    int errors = 0;

    demux_dispatch_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_dest      (in_dest),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_hold      (in_hold),
        .out_data     (out_data),
        .out_sel      (out_sel),
        .out_valid    (out_valid),
        .out_count    (out_count),
        .out_drop_cnt (out_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  dest;
        logic [95:0] data;
    } ent_t;

    typedef struct {
        logic [6:0]  dest;
        logic [95:0] data;
        logic        exp_valid;
    } vec_t;

    ent_t        mq[$];
    logic        exp_valid;
    logic [95:0] exp_data;
    logic [6:0]  exp_sel;
    logic [15:0] exp_drop;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_sel   = '0;
        exp_drop  = '0;
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    // One clock: drive inputs, advance the model by the FIFO rules, compare everything.
    task automatic cycle(input logic v, input logic [6:0] d, input logic [95:0] x,
                         input logic h, output bit acc);
        int   sz;
        ent_t e;
        in_valid = v; in_dest = d; in_data = x; in_hold = h;
        sz = mq.size();
        #1 chk("in_ready", in_ready, sz != 16);
        acc = v && (sz != 16);
        @(posedge clk);
        if (sz != 0 && !h) begin
            e = mq.pop_front();
            if (e.dest < 100) begin
                exp_valid = 1'b1; exp_sel = e.dest; exp_data = e.data;
            end else begin
                exp_valid = 1'b0;
                if (exp_drop != 16'hFFFF) exp_drop++;
            end
        end else begin
            exp_valid = 1'b0;
        end
        if (acc) mq.push_back('{d, x});
        #1;
        chk("out_valid", out_valid, exp_valid);
        chk("out_sel", out_sel, exp_sel);
        chk("out_data", out_data, exp_data);
        chk("out_count", out_count, mq.size());
        chk("out_drop_cnt", out_drop_cnt, exp_drop);
    endtask

    initial begin
        vec_t tbl[6];
        bit   acc;
        int   n;

        tbl[0] = '{7'd7,   96'h1,                         1'b1};
        tbl[1] = '{7'd99,  96'hAAAA_5555_0000_FFFF_1234_5678, 1'b1};
        tbl[2] = '{7'd100, 96'hDEAD_BEEF,                  1'b0};
        tbl[3] = '{7'd127, 96'hCAFE,                       1'b0};
        tbl[4] = '{7'd3,   96'h3F80_0000_4000_0000_4040_0000, 1'b1};
        tbl[5] = '{7'd0,   96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1};

        rst = 1'b0; in_valid = 0; in_dest = '0; in_data = '0; in_hold = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", out_count, 0);
        chk("rst_drop", out_drop_cnt, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk) rst = 1'b1;

        // Single records into an empty FIFO: strobe one cycle after the push edge.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, tbl[i].dest, tbl[i].data, 1'b0, acc);
            chk("tbl_no_bypass", out_valid, 0);
            cycle(1'b0, '0, '0, 1'b0, acc);
            chk("tbl_valid", out_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                chk("tbl_sel", out_sel, tbl[i].dest);
                chk("tbl_data", out_data, tbl[i].data);
            end
        end
        chk("tbl_drops", out_drop_cnt, 2);

        // Fill under hold, then drain in order.
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 7'(i), rnd96(), 1'b1, acc);
            if (in_ready === 1'b0 && i < 15) n = -100;
            n += int'(acc);
        end
        chk("fill_accepts", n, 16);
        chk("fill_count", out_count, 16);
        chk("fill_ready", in_ready, 0);
        n = 0;
        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, '0, '0, 1'b0, acc);
            n += int'(out_valid);
        end
        chk("drain_strobes", n, 16);

        // Full with pop: no accept on the popping cycle, accept on the next.
        for (int i = 0; i < 16; i++) cycle(1'b1, 7'(40 + i), rnd96(), 1'b1, acc);
        cycle(1'b1, 7'd5, rnd96(), 1'b0, acc);
        chk("fullpop_count", out_count, 15);
        cycle(1'b1, 7'd6, rnd96(), 1'b1, acc);
        chk("refill_count", out_count, 16);
        repeat (18) cycle(1'b0, '0, '0, 1'b0, acc);

        // Streaming through pointer wrap at 16 and 32.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 7'(i), rnd96(), 1'b0, acc);
            chk("stream_count", out_count, 1);
        end
        repeat (2) cycle(1'b0, '0, '0, 1'b0, acc);

        // Random traffic, mixed legal/illegal destinations and holds.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 7'($urandom_range(0, 127)), rnd96(),
                  $urandom_range(0, 3) == 0, acc);
        repeat (20) cycle(1'b0, '0, '0, 1'b0, acc);

        // Asynchronous reset with entries buffered and a strobe in flight.
        for (int i = 0; i < 5; i++) cycle(1'b1, 7'(10 + i), rnd96(), 1'b1, acc);
        cycle(1'b0, '0, '0, 1'b0, acc);
        chk("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_count", out_count, 0);
        model_reset();
        @(negedge clk) rst = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_drop", out_drop_cnt, 0);
        chk("post_rst_count", out_count, 0);
        repeat (3) cycle(1'b0, '0, '0, 1'b0, acc);

        // Drop counter saturation.
        for (int i = 0; i < 70000; i++) cycle(1'b1, 7'd127, '0, 1'b0, acc);
        repeat (2) cycle(1'b0, '0, '0, 1'b0, acc);
        chk("drop_saturated", out_drop_cnt, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
